// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes and selects
// combinationally from the current state and the IR contents.
// Optional feature macro: CTRL_OV_TRAP_EN. When defined, signed add/sub/addi
// overflow in EXEC skips write-back and pulses exc_ov for one cycle.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic [3:0]  aluc,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  pc_src_sel,
  output logic [1:0]  rf_dst_sel,
  output logic [1:0]  wb_sel,
  output logic        exc_ov,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_NONE, K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_t;

  state_t      cur;
  state_t      nxt;
  kind_t       kind;
  logic [3:0]  dec_aluc;
  logic [1:0]  dec_asel;
  logic [1:0]  dec_bsel;
  logic        dec_ovchk;
  logic        trap;
  logic        taken;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        unused_ok;

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign state     = cur;
  assign unused_ok = ^{instr[25:6], alu_overflow, dec_ovchk};

  // Classify the IR into an instruction kind plus its EXEC-phase ALU controls.
  always_comb begin
    kind      = K_NONE;
    dec_aluc  = 4'b0000;
    dec_asel  = 2'd1;
    dec_bsel  = 2'd0;
    dec_ovchk = 1'b0;
    case (op)
      6'h00: begin
        kind = K_RALU;
        case (fn)
          6'h00: begin dec_aluc = 4'b1110; dec_asel = 2'd2; end
          6'h02: begin dec_aluc = 4'b1101; dec_asel = 2'd2; end
          6'h03: begin dec_aluc = 4'b1100; dec_asel = 2'd2; end
          6'h04: dec_aluc = 4'b1110;
          6'h06: dec_aluc = 4'b1101;
          6'h07: dec_aluc = 4'b1100;
          6'h08: kind = K_JR;
          6'h20: begin dec_aluc = 4'b0010; dec_ovchk = 1'b1; end
          6'h21: dec_aluc = 4'b0000;
          6'h22: begin dec_aluc = 4'b0011; dec_ovchk = 1'b1; end
          6'h23: dec_aluc = 4'b0001;
          6'h24: dec_aluc = 4'b0100;
          6'h25: dec_aluc = 4'b0101;
          6'h26: dec_aluc = 4'b0110;
          6'h27: dec_aluc = 4'b0111;
          6'h2A: dec_aluc = 4'b1011;
          6'h2B: dec_aluc = 4'b1010;
          default: kind = K_NONE;
        endcase
      end
      6'h08: begin kind = K_IALU; dec_aluc = 4'b0010; dec_bsel = 2'd2; dec_ovchk = 1'b1; end
      6'h09: begin kind = K_IALU; dec_aluc = 4'b0000; dec_bsel = 2'd2; end
      6'h0A: begin kind = K_IALU; dec_aluc = 4'b1011; dec_bsel = 2'd2; end
      6'h0B: begin kind = K_IALU; dec_aluc = 4'b1010; dec_bsel = 2'd2; end
      6'h0C: begin kind = K_IALU; dec_aluc = 4'b0100; dec_bsel = 2'd3; end
      6'h0D: begin kind = K_IALU; dec_aluc = 4'b0101; dec_bsel = 2'd3; end
      6'h0E: begin kind = K_IALU; dec_aluc = 4'b0110; dec_bsel = 2'd3; end
      6'h0F: begin kind = K_IALU; dec_aluc = 4'b1000; dec_bsel = 2'd3; end
      6'h23: kind = K_LW;
      6'h2B: kind = K_SW;
      6'h04: kind = K_BEQ;
      6'h05: kind = K_BNE;
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      default: kind = K_NONE;
    endcase
  end

`ifdef CTRL_OV_TRAP_EN
  assign trap = (cur == S_EXEC) && dec_ovchk && alu_overflow;

  // Register the overflow trap so exc_ov is a one-cycle pulse after EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_ov <= 1'b0;
    else        exc_ov <= trap;
  end
`else
  assign trap   = 1'b0;
  assign exc_ov = 1'b0;
`endif

  // State register; reset abandons any in-flight access and restarts at FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state and datapath controls; everything idles while reset is low.
  always_comb begin
    nxt        = cur;
    aluc       = 4'b0000;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 2'd0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    pc_src_sel = 2'd0;
    rf_dst_sel = 2'd0;
    wb_sel     = 2'd0;
    halted     = 1'b0;
    taken      = (kind == K_BEQ) ? alu_zero : !alu_zero;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_b_sel = 2'd1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: nxt = (kind == K_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        nxt = S_FETCH;
        case (kind)
          K_RALU, K_IALU: begin
            aluc      = dec_aluc;
            alu_a_sel = dec_asel;
            alu_b_sel = dec_bsel;
            nxt       = trap ? S_FETCH : S_WB;
          end
          K_LW, K_SW: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 2'd2;
            nxt       = S_MEM;
          end
          K_BEQ, K_BNE: begin
            aluc      = 4'b0001;
            alu_a_sel = 2'd1;
            if (taken) begin
              pc_we      = 1'b1;
              pc_src_sel = 2'd1;
            end
          end
          K_J: begin
            pc_we      = 1'b1;
            pc_src_sel = 2'd2;
          end
          K_JAL: begin
            pc_we      = 1'b1;
            pc_src_sel = 2'd2;
            rf_we      = 1'b1;
            rf_dst_sel = 2'd2;
            wb_sel     = 2'd2;
          end
          K_JR: begin
            pc_we      = 1'b1;
            pc_src_sel = 2'd3;
          end
          default: nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (kind == K_SW);
        if (mem_ready) nxt = (kind == K_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we = 1'b1;
        nxt   = S_FETCH;
        if (kind == K_LW)        wb_sel     = 2'd1;
        else if (kind == K_RALU) rf_dst_sel = 2'd1;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_FETCH;
    endcase
    if (!rst_n) begin
      aluc       = 4'b0000;
      alu_a_sel  = 2'd0;
      alu_b_sel  = 2'd0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      rf_we      = 1'b0;
      pc_src_sel = 2'd0;
      rf_dst_sel = 2'd0;
      wb_sel     = 2'd0;
      halted     = 1'b0;
    end
  end

endmodule
